// File: rtl/sram_like_pkg.sv
// Shared types and helpers for the pipeline-port to SRAM-like bus bridge:
// FSM state encoding, bus transfer-size codes and byte-enable decoding.
package sram_like_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Only naturally aligned byte/half/word enables are legal; others fall back to word.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
      4'b0011, 4'b1100:                   size = SIZE_H;
      default:                            size = SIZE_W;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/sram_like_discard_cnt.sv
// Saturating up/down counter tracking flushed bus transactions whose
// responses must still be dropped.
module sram_like_discard_cnt #(
  parameter int MAX_DISCARD = 3,
  localparam int CNT_W = $clog2(MAX_DISCARD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero
);

  logic [CNT_W-1:0] cnt_r;

  assign full    = (cnt_r == CNT_W'(MAX_DISCARD));
  assign nonzero = (cnt_r != {CNT_W{1'b0}});

  // Counter update; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc & ~dec & ~full) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else if (dec & ~inc & nonzero) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from a single-cycle, stall-based pipeline SRAM port to the
// SRAM-like split-handshake bus, with flush-safe response discarding.
module sram_like_bridge
  import sram_like_pkg::*;
#(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 32,
  parameter bit         WRITE_EN    = 1'b0,
  parameter int         MAX_DISCARD = 3,
  parameter logic [1:0] READ_SIZE   = 2'b10,
  localparam int        WEN_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              longest_stall,
  input  logic              flush,
  input  logic              sram_en,
  input  logic [WEN_W-1:0]  sram_wen,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t            state_r, state_n;
  logic              req_kill_r, req_kill_n;
  logic              bus_req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;

  logic       inc_s, dec_s, full_s, nonzero_s;
  logic       issue_s, capture_s, own_data_s;
  logic       wr_s;
  logic [1:0] wsize_s;

  assign wr_s       = WRITE_EN & (sram_wen != {WEN_W{1'b0}});
  assign wsize_s    = wen_to_size(4'(sram_wen));
  // A data_ok belongs to the current access only once older killed ones have drained.
  assign own_data_s = bus_data_ok & ~nonzero_s;
  assign dec_s      = bus_data_ok & nonzero_s;

  sram_like_discard_cnt #(
    .MAX_DISCARD (MAX_DISCARD)
  ) u_discard_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc_s),
    .dec     (dec_s),
    .full    (full_s),
    .nonzero (nonzero_s)
  );

  // Next-state, kill tracking, discard increment and capture strobes.
  always_comb begin
    state_n    = state_r;
    req_kill_n = 1'b0;
    inc_s      = 1'b0;
    issue_s    = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // A draining response frees a discard slot in the same cycle.
        if (sram_en & ~flush & (~full_s | dec_s)) begin
          state_n = ADDR;
          issue_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (req_kill_r | flush) begin
            state_n = IDLE;
            inc_s   = ~own_data_s;
          end else if (own_data_s) begin
            state_n   = DONE;
            capture_s = ~wr_r;
          end else begin
            state_n = DATA;
          end
        end else begin
          // Request stays on the bus until accepted, even after a flush.
          state_n    = ADDR;
          req_kill_n = req_kill_r | flush;
        end
      end
      DATA: begin
        if (own_data_s) begin
          if (req_kill_r | flush) begin
            state_n = IDLE;
          end else begin
            state_n   = DONE;
            capture_s = ~wr_r;
          end
        end else if (flush) begin
          state_n = IDLE;
          inc_s   = 1'b1;
        end else begin
          state_n = DATA;
        end
      end
      DONE: begin
        if (~longest_stall | flush) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, kill flag and registered bus request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      req_kill_r <= 1'b0;
      bus_req_r  <= 1'b0;
    end else begin
      state_r    <= state_n;
      req_kill_r <= req_kill_n;
      bus_req_r  <= (state_n == ADDR);
    end
  end

  // Request field latches, loaded only when a new access is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      wdata_r <= {DATA_W{1'b0}};
    end else if (issue_s) begin
      addr_r  <= sram_addr;
      wr_r    <= wr_s;
      size_r  <= wr_s ? wsize_s : READ_SIZE;
      wdata_r <= sram_wdata;
    end else begin
      addr_r  <= addr_r;
      wr_r    <= wr_r;
      size_r  <= size_r;
      wdata_r <= wdata_r;
    end
  end

  // Read data capture for the current, unkilled read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      rdata_r <= bus_rdata;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign stall      = sram_en & (state_r != DONE);
  assign bus_req    = bus_req_r;
  assign bus_wr     = wr_r;
  assign bus_size   = size_r;
  assign bus_addr   = addr_r;
  assign bus_wdata  = wdata_r;
  assign sram_rdata = rdata_r;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed self-checking bench for sram_like_bridge (data-port configuration).
module tb_sram_like_bridge;

  logic        clk;
  logic        rst;
  logic        longest_stall;
  logic        flush;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  sram_like_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .WRITE_EN    (1'b1),
    .MAX_DISCARD (3),
    .READ_SIZE   (2'b10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .longest_stall (longest_stall),
    .flush         (flush),
    .sram_en       (sram_en),
    .sram_wen      (sram_wen),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_wr        (bus_wr),
    .bus_size      (bus_size),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_addr_ok   (bus_addr_ok),
    .bus_data_ok   (bus_data_ok),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_wen(input logic [3:0] w);
    return (w == 4'b0001) || (w == 4'b0010) || (w == 4'b0100) || (w == 4'b1000) ||
           (w == 4'b0011) || (w == 4'b1100) || (w == 4'b1111);
  endfunction

  // Any write presented to the bridge must use an aligned byte/half/word enable.
  always @(negedge clk) begin
    if (sram_en && (sram_wen != 4'b0000)) begin
      assert (legal_wen(sram_wen)) else begin
        miss_cnt++;
        $error("FAIL illegal_wen: observed %b", sram_wen);
      end
    end
  end

  logic [3:0] wen_tab  [5] = '{4'b1100, 4'b0001, 4'b1000, 4'b0011, 4'b1111};
  logic [1:0] size_tab [5] = '{2'b01,   2'b00,   2'b00,   2'b01,   2'b10};

  initial begin
    rst = 1'b1; longest_stall = 1'b0; flush = 1'b0; sram_en = 1'b0;
    sram_wen = 4'b0000; sram_addr = 32'h0; sram_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;

    // Reset values
    tick();
    chk("rst_bus_req", 64'(bus_req), 64'h0);
    chk("rst_bus_wr", 64'(bus_wr), 64'h0);
    chk("rst_bus_addr", 64'(bus_addr), 64'h0);
    chk("rst_bus_size", 64'(bus_size), 64'h0);
    chk("rst_rdata", 64'(sram_rdata), 64'h0);
    chk("rst_stall_lo", 64'(stall), 64'h0);
    sram_en = 1'b1; #1;
    chk("rst_stall_follows_en", 64'(stall), 64'h1);
    sram_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // 1: basic read, slave answers one cycle after req
    sram_en = 1'b1; sram_addr = 32'hBFC00000; #1;
    chk("t1_stall_c0", 64'(stall), 64'h1);
    chk("t1_req_c0", 64'(bus_req), 64'h0);
    tick();
    chk("t1_req_c1", 64'(bus_req), 64'h1);
    chk("t1_addr", 64'(bus_addr), 64'hBFC00000);
    chk("t1_wr", 64'(bus_wr), 64'h0);
    chk("t1_size", 64'(bus_size), 64'h2);
    tick();
    chk("t1_req_c2", 64'(bus_req), 64'h1);
    chk("t1_stall_c2", 64'(stall), 64'h1);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h3C080001;
    tick();
    chk("t1_stall_c3", 64'(stall), 64'h0);
    chk("t1_req_c3", 64'(bus_req), 64'h0);
    chk("t1_rdata", 64'(sram_rdata), 64'h3C080001);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; sram_en = 1'b0;
    tick();
    chk("t1_req_idle", 64'(bus_req), 64'h0);

    // 2: flush in DATA, stale response dropped, next read captured
    sram_en = 1'b1; sram_addr = 32'h20;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    chk("t2_req_data", 64'(bus_req), 64'h0);
    chk("t2_stall_data", 64'(stall), 64'h1);
    bus_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; sram_en = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD0000;
    tick();
    chk("t2_stale_dropped", 64'(sram_rdata), 64'h3C080001);
    bus_data_ok = 1'b0; sram_en = 1'b1; sram_addr = 32'h10;
    tick();
    chk("t2_addr2", 64'(bus_addr), 64'h10);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234;
    tick();
    chk("t2_rdata", 64'(sram_rdata), 64'h1234);
    chk("t2_stall", 64'(stall), 64'h0);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; sram_en = 1'b0;
    tick();

    // 3: flush in ADDR with addr_ok held low 4 cycles
    sram_en = 1'b1; sram_addr = 32'h40;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; sram_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      chk("t3_req_held", 64'(bus_req), 64'h1);
      chk("t3_addr_held", 64'(bus_addr), 64'h40);
      if (i < 3) tick();
    end
    bus_addr_ok = 1'b1;
    tick();
    chk("t3_req_after_kill", 64'(bus_req), 64'h0);
    bus_addr_ok = 1'b0;
    tick();
    chk("t3_new_req", 64'(bus_req), 64'h1);
    chk("t3_new_addr", 64'(bus_addr), 64'h80);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hBAD0BAD0;
    tick();
    chk("t3_killed_not_captured", 64'(sram_rdata), 64'h1234);
    chk("t3_stall_wait", 64'(stall), 64'h1);
    bus_addr_ok = 1'b0; bus_rdata = 32'h5555AAAA;
    tick();
    chk("t3_rdata", 64'(sram_rdata), 64'h5555AAAA);
    chk("t3_stall_done", 64'(stall), 64'h0);
    bus_data_ok = 1'b0; sram_en = 1'b0;
    tick();

    // 4: fill the discard counter, then one data_ok releases a new req
    for (int i = 0; i < 3; i++) begin
      sram_en = 1'b1; sram_addr = 32'h100 + 32'(i * 4);
      tick();
      chk("t4_req_issue", 64'(bus_req), 64'h1);
      bus_addr_ok = 1'b1; flush = 1'b1;
      tick();
      bus_addr_ok = 1'b0; flush = 1'b0;
    end
    sram_addr = 32'h200;
    tick();
    chk("t4_full_no_req", 64'(bus_req), 64'h0);
    chk("t4_full_stall", 64'(stall), 64'h1);
    tick();
    chk("t4_full_no_req2", 64'(bus_req), 64'h0);
    bus_data_ok = 1'b1; bus_rdata = 32'h0BAD0BAD;
    tick();
    chk("t4_req_released", 64'(bus_req), 64'h1);
    chk("t4_addr", 64'(bus_addr), 64'h200);
    bus_addr_ok = 1'b1;
    tick();
    chk("t4_stall_drain1", 64'(stall), 64'h1);
    chk("t4_rdata_kept1", 64'(sram_rdata), 64'h5555AAAA);
    bus_addr_ok = 1'b0;
    tick();
    chk("t4_stall_drain2", 64'(stall), 64'h1);
    chk("t4_rdata_kept2", 64'(sram_rdata), 64'h5555AAAA);
    bus_rdata = 32'h600D600D;
    tick();
    chk("t4_rdata", 64'(sram_rdata), 64'h600D600D);
    bus_data_ok = 1'b0; sram_en = 1'b0;
    tick();

    // 5: writes, size encoding, read data untouched
    for (int i = 0; i < 5; i++) begin
      sram_en = 1'b1; sram_wen = wen_tab[i];
      sram_addr = 32'h102; sram_wdata = 32'hAABB0000;
      tick();
      chk("t5_wr", 64'(bus_wr), 64'h1);
      chk("t5_size", 64'(bus_size), 64'(size_tab[i]));
      chk("t5_addr", 64'(bus_addr), 64'h102);
      chk("t5_wdata", 64'(bus_wdata), 64'hAABB0000);
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFFFFFF;
      tick();
      chk("t5_stall_done", 64'(stall), 64'h0);
      chk("t5_rdata_kept", 64'(sram_rdata), 64'h600D600D);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; sram_en = 1'b0; sram_wen = 4'b0000;
      tick();
    end

    // 6: longest_stall holds DONE, then reset mid-DATA
    sram_en = 1'b1; sram_addr = 32'h300;
    tick();
    chk("t6_wr_read", 64'(bus_wr), 64'h0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h77778888; longest_stall = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("t6_hold_rdata", 64'(sram_rdata), 64'h77778888);
      chk("t6_hold_no_req", 64'(bus_req), 64'h0);
      chk("t6_hold_stall", 64'(stall), 64'h0);
      tick();
    end
    longest_stall = 1'b0; sram_en = 1'b0;
    tick();
    sram_en = 1'b1; sram_addr = 32'h400;
    tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    rst = 1'b1; #1;
    chk("t6_rst_req", 64'(bus_req), 64'h0);
    chk("t6_rst_addr", 64'(bus_addr), 64'h0);
    chk("t6_rst_rdata", 64'(sram_rdata), 64'h0);
    chk("t6_rst_stall", 64'(stall), 64'h1);
    sram_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    sram_en = 1'b1; sram_addr = 32'h500;
    tick();
    chk("t6_post_rst_req", 64'(bus_req), 64'h1);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE;
    tick();
    chk("t6_post_rst_rdata", 64'(sram_rdata), 64'hCAFE);
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; sram_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/sram_like_bridge.md
# sram_like_bridge

Parametrised bridge between a pipeline-stage SRAM port (single-cycle request, stall-based) and the SRAM-like bus (req/addr_ok/data_ok split handshake). It replaces the per-port instruction-only adapter. One instance serves either the fetch port or the memory-stage port, selected by parameter. It adds write support, byte-size encoding, a held request across flush, and discard of in-flight responses killed by a flush.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; `WEN_W = DATA_W/8`.
- `WRITE_EN`, default 0: 0 = instruction port (`bus_wr` tied 0, `sram_wen` ignored); 1 = data port.
- `MAX_DISCARD`, default 3: maximum outstanding flushed transactions whose responses are dropped; counter width is `$clog2(MAX_DISCARD+1)`.
- `READ_SIZE`, default 2'b10: `bus_size` for reads.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous and active-high.
- `longest_stall` in 1: pipeline-wide stall; holds the DONE result.
- `flush` in 1: kills the current CPU-side access.
- `sram_en` in 1: CPU access request. Held while `stall` is high.
- `sram_wen` in WEN_W: byte write enables; all-zero = read.
- `sram_addr` in ADDR_W: byte address.
- `sram_wdata` in DATA_W: write data.
- `sram_rdata` out DATA_W: captured read data, stable in DONE.
- `stall` out 1: `sram_en & (state != DONE)`.
- `bus_req` out 1, `bus_wr` out 1, `bus_size` out 2, `bus_addr` out ADDR_W, `bus_wdata` out DATA_W: SRAM-like request channel.
- `bus_addr_ok` in 1, `bus_data_ok` in 1, `bus_rdata` in DATA_W: SRAM-like response channel; responses are in order.

## Operation
States:
- IDLE
- ADDR: `bus_req` high, waiting for `bus_addr_ok`.
- DATA: waiting for `bus_data_ok`.
- DONE: result held.

`req_kill` flag: the current transaction was flushed and its response is to be discarded.

Transitions:
- IDLE: if `sram_en & ~flush & (disc_cnt < MAX_DISCARD)`, latch addr/wr/size/wdata and go to ADDR. Request fields come from the latches, never from live inputs.
- ADDR: on `bus_addr_ok` go to DATA. If `bus_data_ok` arrives in the same cycle and `disc_cnt == 0`, go straight to DONE.
- DATA: on `bus_data_ok` with `disc_cnt == 0`, go to DONE. With `req_kill` set, go to IDLE and drop the data.
- DONE: `~longest_stall` or `flush` leads to IDLE.

Flush rules:
- Flush in ADDR: `bus_req` stays high with unchanged fields until `addr_ok`. Set `req_kill`, let `stall` follow `sram_en`, and let the CPU side proceed.
- Flush in DATA, or ADDR+`addr_ok` after kill: increment `disc_cnt`, go to IDLE.
- Flush in DATA in the same cycle as `data_ok`: drop the data, go to IDLE, `disc_cnt` unchanged.

`disc_cnt` behaviour:
- Any `bus_data_ok` while `disc_cnt > 0` decrements it and is never captured.
- Increment and decrement in the same cycle leaves it unchanged.
- At `disc_cnt == MAX_DISCARD`, no new request is issued (stays in IDLE, `stall` high).

Write size (WRITE_EN=1):
- wen 0001/0010/0100/1000 → 2'b00.
- wen 0011/1100 → 2'b01.
- wen 1111 → 2'b10.
- Any other pattern is illegal; the bench asserts on it.

`sram_rdata` updates only on a captured read `data_ok`. Writes leave it unchanged.

## Timing
- Reset values: state IDLE, `disc_cnt` 0, `req_kill` 0, `bus_req` 0, `bus_wr` 0, `sram_rdata` 0, request latches 0. `stall` equals `sram_en` during reset.
- `bus_req` first rises the cycle after `sram_en` is seen in IDLE (registered). It is never lowered before `addr_ok`.
- Minimum read latency with `addr_ok` and `data_ok` in the same cycle as req: `stall` falls 2 cycles after `sram_en` rises.
- `stall` is combinational from `sram_en` and the state. No combinational path from `bus_*` inputs to `bus_req`.
- Reset mid-transaction abandons all outstanding bus state. The interconnect is reset together with the bridge.

## Structure
- Package `sram_like_pkg`: state enum (IDLE/ADDR/DATA/DONE), size constants SIZE_B/SIZE_H/SIZE_W, and the wen-to-size function.
- Sub-module `sram_like_discard_cnt`: saturating up/down counter parametrised by MAX_DISCARD, with `full` and `nonzero` outputs.
- All other logic (FSM, latches) lives in the top module.

## Test plan
1. Read, slave gives `addr_ok` and `data_ok` 1 cycle after req, addr 0xBFC00000, rdata 0x3C080001 → `sram_rdata` = 0x3C080001, `stall` falls on cycle 3, one req pulse.
2. Flush in DATA, then the slave returns 0xDEAD0000 → counter 1→0, data not captured. The next read of 0x10 returns 0x1234 and is captured.
3. Flush while in ADDR with `addr_ok` held low 4 cycles → `bus_req`/`bus_addr` stable all 4 cycles, then the response is discarded.
4. Three consecutive flushed reads with MAX_DISCARD=3 and no `data_ok` → a 4th `sram_en` gets no req and `stall` high. First `data_ok` → req issues next cycle.
5. WRITE_EN=1, wen 0b1100 to addr 0x102, wdata 0xAABB0000 → `bus_wr`=1, `bus_size`=2'b01, `sram_rdata` unchanged.
6. `longest_stall` high 5 cycles in DONE → rdata held, no new req. Assert `rst` mid-DATA → all outputs at reset values immediately.
